// File: rtl/screen_msg_builder.sv
// screen_msg_builder
// Turns piano key events (note codes 0-12) into short serial-LCD text
// messages (note letter, accidental, octave digit) and presents them one
// 10-bit UART frame at a time to the screen transmitter via ovalid/oready.
// A small FIFO holds key events that arrive while a message is being sent.
// Build option: define SCREEN_CLEAR_EN to prefix every message with the
// clear-display sequence 0xFE 0x01 (5 bytes per message instead of 3).
`timescale 1ns/1ps
module screen_msg_builder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int OCTAVE_BASE = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       ovalid,
    input  logic       oready,
    output logic [9:0] frame,
    output logic       busy,
    output logic       drop_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

`ifdef SCREEN_CLEAR_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd2;
`endif

    localparam logic [9:0] FRAME_IDLE = 10'h3FF;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    state_t        r_state;
    logic [3:0]    r_code;
    logic [2:0]    r_idx;
    logic          r_ovalid;
    logic [9:0]    r_frame;
    logic          r_drop_err;

    logic w_push;
    logic w_store;
    logic w_pop;

    // Character for a given note code and position within the message.
    function automatic logic [7:0] msg_byte(input logic [3:0] code, input logic [2:0] idx);
        logic [7:0] letter;
        logic [7:0] accid;
        logic [7:0] digit;
        logic [2:0] pos;
        case (code)
            4'd0, 4'd1, 4'd12: letter = 8'h43;
            4'd2, 4'd3:        letter = 8'h44;
            4'd4:              letter = 8'h45;
            4'd5, 4'd6:        letter = 8'h46;
            4'd7, 4'd8:        letter = 8'h47;
            4'd9, 4'd10:       letter = 8'h41;
            default:           letter = 8'h42;
        endcase
        case (code)
            4'd1, 4'd3, 4'd6, 4'd8, 4'd10: accid = 8'h23;
            default:                       accid = 8'h20;
        endcase
        digit = 8'h30 + 8'(OCTAVE_BASE) + ((code == 4'd12) ? 8'd1 : 8'd0);
`ifdef SCREEN_CLEAR_EN
        pos = idx - 3'd2;
        if (idx == 3'd0) begin
            return 8'hFE;
        end else if (idx == 3'd1) begin
            return 8'h01;
        end
`else
        pos = idx;
`endif
        case (pos)
            3'd0:    return letter;
            3'd1:    return accid;
            default: return digit;
        endcase
    endfunction

    assign key_ready = (r_count < CW'(FIFO_DEPTH));
    assign w_push    = key_valid && key_ready;
    assign w_store   = w_push && (key_code <= 4'd12);
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);

    assign ovalid   = r_ovalid;
    assign frame    = r_frame;
    assign drop_err = r_drop_err;
    assign busy     = (r_state != S_IDLE) || (r_count != '0);

    // FIFO storage; contents are meaningless once count says empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= key_code;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Out-of-range codes are swallowed and flagged for exactly one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_err <= 1'b0;
        end else begin
            r_drop_err <= w_push && (key_code > 4'd12);
        end
    end

    // Message sequencer: pop one event, then walk its bytes with registered frame/ovalid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_code   <= '0;
            r_idx    <= '0;
            r_ovalid <= 1'b0;
            r_frame  <= FRAME_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_code   <= r_mem[r_rd_ptr];
                        r_idx    <= '0;
                        r_ovalid <= 1'b1;
                        r_frame  <= {1'b1, msg_byte(r_mem[r_rd_ptr], 3'd0), 1'b0};
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (r_ovalid && oready) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx    <= '0;
                            r_ovalid <= 1'b0;
                            r_frame  <= FRAME_IDLE;
                            r_state  <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_frame <= {1'b1, msg_byte(r_code, r_idx + 3'd1), 1'b0};
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_ovalid <= 1'b0;
                    r_frame  <= FRAME_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_screen_msg_builder.sv
// Testbench for screen_msg_builder: directed steps with a frame scoreboard.
`timescale 1ns/1ps
module tb_screen_msg_builder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       ovalid;
    logic       oready;
    logic [9:0] frame;
    logic       busy;
    logic       drop_err;

    int checks = 0;
    int errors = 0;
    int hs     = 0;
    logic [9:0] q[$];
    logic       pend = 1'b0;
    logic [9:0] pend_frame = 10'h3FF;

`ifdef SCREEN_CLEAR_EN
    localparam int MSG_LEN = 5;
    localparam logic [9:0] FIRST_C_SHARP = 10'h3FC;
`else
    localparam int MSG_LEN = 3;
    localparam logic [9:0] FIRST_C_SHARP = 10'h286;
`endif

    screen_msg_builder #(.FIFO_DEPTH(4), .OCTAVE_BASE(4)) dut (
        .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .ovalid(ovalid), .oready(oready), .frame(frame),
        .busy(busy), .drop_err(drop_err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] fr(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Reference model: expected frames for one note code.
    task automatic expect_msg(input logic [3:0] c);
        string         letters = "CCDDEFFGGAABC";
        logic [12:0]   sharp   = 13'b0010101001010;
        logic [7:0]    oct;
        if (c > 4'd12) return;
`ifdef SCREEN_CLEAR_EN
        q.push_back(fr(8'hFE));
        q.push_back(fr(8'h01));
`endif
        q.push_back(fr(letters[c]));
        q.push_back(fr(sharp[c] ? 8'h23 : 8'h20));
        oct = (c == 4'd12) ? 8'd5 : 8'd4;
        q.push_back(fr(8'h30 + oct));
    endtask

    task automatic push(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        expect_msg(c);
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        oready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (q.size() == 0 && !busy) break;
        end
        chk({tag, "_drained"}, {31'd0, (q.size() == 0 && !busy && !ovalid)}, 32'd1);
    endtask

    // Scoreboard/monitor: a handshake happens at the next posedge when both are high here.
    always @(negedge clk) begin
        if (!reset_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("hold_valid", {31'd0, ovalid}, 32'd1);
                chk("hold_frame", {22'd0, frame}, {22'd0, pend_frame});
            end
            if (ovalid && oready) begin
                hs++;
                chk("frame_expected", {31'd0, (q.size() != 0)}, 32'd1);
                if (q.size() != 0) chk("frame", {22'd0, frame}, {22'd0, q.pop_front()});
            end
            pend       = ovalid && !oready;
            pend_frame = frame;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        logic found;
        reset_n = 1'b0; key_valid = 1'b0; key_code = 4'd0; oready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_ready", {31'd0, key_ready}, 32'd1);
        chk("rst_ovalid",    {31'd0, ovalid},    32'd0);
        chk("rst_frame",     {22'd0, frame},     32'h3FF);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_drop_err",  {31'd0, drop_err},  32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // C# with oready high: check pop latency then the full message
        oready = 1'b1;
        push(4'd1);
        chk("lat_after_push", {31'd0, ovalid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_after_pop", {31'd0, ovalid}, 32'd1);
        chk("lat_first_frame", {22'd0, frame}, {22'd0, FIRST_C_SHARP});
        drain("c_sharp");

        // High C: exact handshake count
        hs0 = hs;
        push(4'd12);
        drain("high_c");
        chk("high_c_handshakes", hs - hs0, MSG_LEN);

        // Slow transmitter: long oready-low gaps, frames must hold
        oready = 1'b0;
        push(4'd7);
        push(4'd10);
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            oready = 1'b1;
            @(posedge clk); #1;
            oready = 1'b0;
            repeat (20) @(posedge clk);
            #1;
        end
        drain("slow");

        // Fill FIFO while builder is stalled
        oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(4'(i));
            chk($sformatf("fill_ready_%0d", i), {31'd0, key_ready}, (i == 4) ? 32'd0 : 32'd1);
        end
        key_valid = 1'b1; key_code = 4'd5;
        @(posedge clk); #1;
        key_valid = 1'b0;
        chk("full_ready", {31'd0, key_ready}, 32'd0);
        drain("fill");

        // Out-of-range code
        push(4'd14);
        chk("drop_pulse", {31'd0, drop_err}, 32'd1);
        chk("drop_no_valid", {31'd0, ovalid}, 32'd0);
        chk("drop_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("drop_single", {31'd0, drop_err}, 32'd0);
        chk("drop_no_valid2", {31'd0, ovalid}, 32'd0);

        // Simultaneous push and pop at count 2
        oready = 1'b0;
        push(4'd2);
        push(4'd4);
        push(4'd5);
        oready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!ovalid) begin found = 1'b1; break; end
        end
        chk("simul_idle_found", {31'd0, found}, 32'd1);
        key_valid = 1'b1; key_code = 4'd7; expect_msg(4'd7);
        oready = 1'b0;
        @(posedge clk); #1;
        key_valid = 1'b0;
        chk("simul_ready_c2", {31'd0, key_ready}, 32'd1);
        push(4'd9);
        chk("simul_ready_c3", {31'd0, key_ready}, 32'd1);
        push(4'd11);
        chk("simul_ready_c4", {31'd0, key_ready}, 32'd0);
        drain("simul");

        // Reset during byte 2 with two events queued
        oready = 1'b0;
        push(4'd0);
        push(4'd3);
        push(4'd6);
        oready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        oready = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ovalid", {31'd0, ovalid}, 32'd0);
        chk("mid_rst_ready", {31'd0, key_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        hs0 = hs;
        oready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("post_rst_no_frames", hs - hs0, 0);
        chk("post_rst_ovalid", {31'd0, ovalid}, 32'd0);
        push(4'd9);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
